zxbus_port_decoder: RTL and testbench
=====================================

Name: zxbus_port_decoder

Overview:
- Bus-side front end of the card's control ports, on fclk.
- Synchronises raw ZX bus I/O cycles, decodes #81AB/#82AB/#83AB and produces the write strobe, enable, address and write data for the port register file.
- On reads, drives that file's read data onto the ZX data bus.
- Sits between the ZX edge-connector pins and the port register block.

Parameters:
SYNC_STAGES, 2, flip-flop depth of the control-signal synchronisers (min 2)
STB_LEN, 2, fclk cycles wrstb_n is held low per write (min 1)
LO_BYTE, 8'hAB, low address byte common to all card ports

Ports:
fclk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
za  input  16  ZX address bus (raw)
zd_in  input  8  ZX data bus input (raw)
ziorq_n  input  1  ZX IORQ, active low (raw)
zrd_n  input  1  ZX RD, active low (raw)
zwr_n  input  1  ZX WR, active low (raw)
zm1_n  input  1  ZX M1, active low (raw)
zd_out  output  8  data to ZX bus on reads
zd_ena  output  1  ZX data bus output enable
iorqge  output  1  tells other ZX devices that this card owns the cycle
port_addr  output  2  port select: 2'b11=#83AB, 2'b10=#82AB, 2'b01=#81AB
port_wrdata  output  8  latched write data
port_wrena  output  1  write enable qualifying wrstb_n
port_wrstb_n  output  1  write strobe; register file latches on its rising edge
port_rddata  input  8  read data from the port register file, combinational on port_addr

Behaviour:
- Reset values (asynchronous, rst_n low): state=IDLE, zd_out=0, zd_ena=0, port_addr=2'b00, port_wrdata=0, port_wrena=0, port_wrstb_n=1, sync chains all 1.
- Reset mid-write forces port_wrstb_n high immediately. This is safe because the register file shares rst_n.
- Synchronisation: ziorq_n, zrd_n, zwr_n and zm1_n each pass through SYNC_STAGES flops. za and zd_in are not synchronised; they are sampled only in the cycle the FSM leaves IDLE, when they are guaranteed stable.
- Hit decode: za[7:0]==LO_BYTE, za[15:8] in {8'h81, 8'h82, 8'h83}, synced m1_n=1. port_addr takes za[9:8].
- iorqge is the only combinational output: raw ziorq_n=0 & zm1_n=1 & raw address hit.
- State IDLE:
  - Synced iorq=0, wr=0, rd=1 and hit: latch port_addr and port_wrdata, set port_wrena=1, port_wrstb_n=0, go to WSTB.
  - Synced iorq=0, rd=0, wr=1 and hit: latch port_addr, go to RD.
  - rd and wr both low, a miss, or m1 low (INTA): stay in IDLE, no outputs change.
- State WSTB:
  - Counts STB_LEN cycles with port_wrstb_n=0.
  - Then sets port_wrstb_n=1 with port_wrena still 1 and port_addr/port_wrdata stable, and goes to WHOLD.
- State WHOLD:
  - port_wrena stays 1 for exactly one cycle after the strobe's rising edge, then clears to 0; go to WEND.
- State WEND:
  - Wait until synced iorq=1 or wr=1, then go to IDLE.
  - A long ZX cycle therefore produces exactly one strobe.
- State RD:
  - zd_ena=1 from the first RD cycle.
  - zd_out is registered from port_rddata every cycle, so it reflects live status bits.
  - When synced iorq=1 or rd=1, zd_ena clears on the next edge; go to IDLE.
- Latency:
  - Write: raw wr/iorq low to port_wrstb_n low = SYNC_STAGES+1 edges.
  - Read: raw rd/iorq low to zd_ena=1 = SYNC_STAGES+1 edges.
  - zd_out is valid 1 cycle after zd_ena rises.
- Back-to-back cycles: a new cycle is recognised only after a return to IDLE. At least one fclk in IDLE is needed between ZX cycles.

Test Plan:
- Write #83AB data 8'h7C, ZX cycle held 10 fclk:
  - port_wrstb_n low at edge 3, for 2 cycles.
  - port_addr=2'b11, port_wrdata=8'h7C, port_wrena=1 through the rising edge and 1 cycle after.
  - Exactly one strobe.
- Read #82AB with port_rddata=8'h35:
  - zd_ena=1 at edge 3; zd_out=8'h35 at edge 4.
  - Change port_rddata to 8'hCA mid-cycle: zd_out follows next cycle.
  - zd_ena=0 one cycle after synced rd rises.
- Misses, no strobe and zd_ena=0 throughout:
  - Write to #84AB or #81AC: iorqge=0.
  - INTA cycle (m1_n=0, iorq_n=0) at address #83AB: iorqge=0.
  - rd_n=wr_n=0 with a hit address.
- Reset asserted while port_wrstb_n=0 in WSTB:
  - All outputs return to reset values asynchronously.
  - After release with the ZX cycle still low, no strobe is issued until a fresh cycle starts.
- Two back-to-back writes, #81AB=8'h01 then #82AB=8'h14, separated by 2 idle fclk: two strobes with the correct addr/data pairs.

Source files
------------

// File: rtl/zxbus_port_decoder.sv
// ZX bus front end for the card's control ports #81AB/#82AB/#83AB.
// Synchronises raw bus cycles and issues one write strobe or one read drive per ZX cycle.
module zxbus_port_decoder #(
    parameter int          SYNC_STAGES = 2,
    parameter int          STB_LEN     = 2,
    parameter logic [7:0]  LO_BYTE     = 8'hAB
) (
    input  logic        fclk,
    input  logic        rst_n,
    input  logic [15:0] za,
    input  logic [7:0]  zd_in,
    input  logic        ziorq_n,
    input  logic        zrd_n,
    input  logic        zwr_n,
    input  logic        zm1_n,
    output logic [7:0]  zd_out,
    output logic        zd_ena,
    output logic        iorqge,
    output logic [1:0]  port_addr,
    output logic [7:0]  port_wrdata,
    output logic        port_wrena,
    output logic        port_wrstb_n,
    input  logic [7:0]  port_rddata
);

    localparam int CW = (STB_LEN > 1) ? $clog2(STB_LEN) : 1;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        WSTB  = 3'd1,
        WHOLD = 3'd2,
        WEND  = 3'd3,
        RD    = 3'd4
    } state_t;

    logic [3:0] w_raw;
    logic [3:0] w_sync;
    logic       w_iorq_n;
    logic       w_rd_n;
    logic       w_wr_n;
    logic       w_m1_n;

    assign w_raw = {zm1_n, zwr_n, zrd_n, ziorq_n};

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_sync
            logic [SYNC_STAGES-1:0] r_chain;
            always_ff @(posedge fclk or negedge rst_n) begin
                if (!rst_n) begin
                    r_chain <= '1;
                end else begin
                    r_chain <= {r_chain[SYNC_STAGES-2:0], w_raw[gi]};
                end
            end
            assign w_sync[gi] = r_chain[SYNC_STAGES-1];
        end
    endgenerate

    assign w_iorq_n = w_sync[0];
    assign w_rd_n   = w_sync[1];
    assign w_wr_n   = w_sync[2];
    assign w_m1_n   = w_sync[3];

    // Synchronisers come out of reset at 1, which would fake a fresh cycle if the
    // bus is already mid-cycle; r_armed waits for a real inactive iorq seen after reset.
    logic [SYNC_STAGES-1:0] r_valid;
    logic                   w_settled;

    always_ff @(posedge fclk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= '0;
        end else begin
            r_valid <= {r_valid[SYNC_STAGES-2:0], 1'b1};
        end
    end
    assign w_settled = r_valid[SYNC_STAGES-1];

    logic w_addr_hit;
    logic w_hit;

    assign w_addr_hit = (za[7:0] == LO_BYTE) &&
                        ((za[15:8] == 8'h81) || (za[15:8] == 8'h82) || (za[15:8] == 8'h83));
    assign w_hit      = w_addr_hit && w_m1_n;
    assign iorqge     = !ziorq_n && zm1_n && w_addr_hit;

    state_t      r_state,        w_state_next;
    logic [CW-1:0] r_cnt,        w_cnt_next;
    logic [7:0]  r_zd_out,       w_zd_out_next;
    logic        r_zd_ena,       w_zd_ena_next;
    logic [1:0]  r_port_addr,    w_port_addr_next;
    logic [7:0]  r_port_wrdata,  w_port_wrdata_next;
    logic        r_port_wrena,   w_port_wrena_next;
    logic        r_port_wrstb_n, w_port_wrstb_n_next;
    logic        r_armed,        w_armed_next;

    always_ff @(posedge fclk or negedge rst_n) begin
        if (!rst_n) begin
            r_state        <= IDLE;
            r_cnt          <= '0;
            r_zd_out       <= 8'h00;
            r_zd_ena       <= 1'b0;
            r_port_addr    <= 2'b00;
            r_port_wrdata  <= 8'h00;
            r_port_wrena   <= 1'b0;
            r_port_wrstb_n <= 1'b1;
            r_armed        <= 1'b0;
        end else begin
            r_state        <= w_state_next;
            r_cnt          <= w_cnt_next;
            r_zd_out       <= w_zd_out_next;
            r_zd_ena       <= w_zd_ena_next;
            r_port_addr    <= w_port_addr_next;
            r_port_wrdata  <= w_port_wrdata_next;
            r_port_wrena   <= w_port_wrena_next;
            r_port_wrstb_n <= w_port_wrstb_n_next;
            r_armed        <= w_armed_next;
        end
    end

    always_comb begin
        w_state_next        = r_state;
        w_cnt_next          = r_cnt;
        w_zd_out_next       = r_zd_out;
        w_zd_ena_next       = r_zd_ena;
        w_port_addr_next    = r_port_addr;
        w_port_wrdata_next  = r_port_wrdata;
        w_port_wrena_next   = r_port_wrena;
        w_port_wrstb_n_next = r_port_wrstb_n;
        w_armed_next        = r_armed;

        case (r_state)
            IDLE: begin
                if (w_settled && w_iorq_n) begin
                    w_armed_next = 1'b1;
                end
                if (r_armed && !w_iorq_n && w_hit) begin
                    if (!w_wr_n && w_rd_n) begin
                        w_port_addr_next    = za[9:8];
                        w_port_wrdata_next  = zd_in;
                        w_port_wrena_next   = 1'b1;
                        w_port_wrstb_n_next = 1'b0;
                        w_cnt_next          = '0;
                        w_state_next        = WSTB;
                    end else if (!w_rd_n && w_wr_n) begin
                        w_port_addr_next = za[9:8];
                        w_zd_ena_next    = 1'b1;
                        w_state_next     = RD;
                    end
                end
            end
            WSTB: begin
                if (r_cnt == CW'(STB_LEN - 1)) begin
                    w_port_wrstb_n_next = 1'b1;
                    w_state_next        = WHOLD;
                end else begin
                    w_cnt_next = r_cnt + 1'b1;
                end
            end
            WHOLD: begin
                w_port_wrena_next = 1'b0;
                w_state_next      = WEND;
            end
            WEND: begin
                if (w_iorq_n || w_wr_n) begin
                    w_state_next = IDLE;
                end
            end
            RD: begin
                w_zd_out_next = port_rddata;
                if (w_iorq_n || w_rd_n) begin
                    w_zd_ena_next = 1'b0;
                    w_state_next  = IDLE;
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    assign zd_out       = r_zd_out;
    assign zd_ena       = r_zd_ena;
    assign port_addr    = r_port_addr;
    assign port_wrdata  = r_port_wrdata;
    assign port_wrena   = r_port_wrena;
    assign port_wrstb_n = r_port_wrstb_n;

endmodule

// File: tb/tb_zxbus_port_decoder.sv
// Directed bench for zxbus_port_decoder: vector table plus timing/reset/back-to-back sequences.
module tb_zxbus_port_decoder;

    logic        fclk = 1'b0;
    logic        rst_n = 1'b1;
    logic [15:0] za = 16'h0000;
    logic [7:0]  zd_in = 8'h00;
    logic        ziorq_n = 1'b1;
    logic        zrd_n = 1'b1;
    logic        zwr_n = 1'b1;
    logic        zm1_n = 1'b1;
    logic [7:0]  zd_out;
    logic        zd_ena;
    logic        iorqge;
    logic [1:0]  port_addr;
    logic [7:0]  port_wrdata;
    logic        port_wrena;
    logic        port_wrstb_n;
    logic [7:0]  port_rddata = 8'h00;

    zxbus_port_decoder #(.SYNC_STAGES(2), .STB_LEN(2), .LO_BYTE(8'hAB)) dut (
        .fclk(fclk), .rst_n(rst_n), .za(za), .zd_in(zd_in),
        .ziorq_n(ziorq_n), .zrd_n(zrd_n), .zwr_n(zwr_n), .zm1_n(zm1_n),
        .zd_out(zd_out), .zd_ena(zd_ena), .iorqge(iorqge),
        .port_addr(port_addr), .port_wrdata(port_wrdata),
        .port_wrena(port_wrena), .port_wrstb_n(port_wrstb_n),
        .port_rddata(port_rddata)
    );

    always #5 fclk = ~fclk;

    int errors = 0;
    int checks = 0;
    int stb_falls = 0;
    logic [1:0] cap_addr = 2'b00;
    logic [7:0] cap_data = 8'h00;
    logic [9:0] cap_q[$];

    always @(negedge port_wrstb_n) stb_falls++;
    always @(posedge port_wrstb_n) begin
        if (rst_n) begin
            cap_addr = port_addr;
            cap_data = port_wrdata;
            cap_q.push_back({port_addr, port_wrdata});
        end
    end

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge fclk);
            #1;
        end
    endtask

    task automatic release_bus();
        ziorq_n = 1'b1;
        zrd_n   = 1'b1;
        zwr_n   = 1'b1;
        zm1_n   = 1'b1;
        step(4);
    endtask

    typedef struct {
        logic [15:0] za;
        logic [7:0]  zd;
        logic        wr_n;
        logic        rd_n;
        logic        m1_n;
        logic [7:0]  rddata;
        int          exp_stb;
        logic [1:0]  exp_addr;
        logic [7:0]  exp_data;
        logic        exp_ena;
        logic [7:0]  exp_zd;
        logic        exp_ge;
    } vec_t;

    vec_t vecs[7];

    initial begin
        int f0;
        logic ena_seen;
        logic ge_seen;

        vecs[0] = '{16'h83AB, 8'h7C, 1'b0, 1'b1, 1'b1, 8'h00, 1, 2'b11, 8'h7C, 1'b0, 8'h00, 1'b1};
        vecs[1] = '{16'h81AB, 8'h01, 1'b0, 1'b1, 1'b1, 8'h00, 1, 2'b01, 8'h01, 1'b0, 8'h00, 1'b1};
        vecs[2] = '{16'h82AB, 8'h00, 1'b1, 1'b0, 1'b1, 8'h35, 0, 2'b10, 8'h00, 1'b1, 8'h35, 1'b1};
        vecs[3] = '{16'h84AB, 8'h55, 1'b0, 1'b1, 1'b1, 8'h00, 0, 2'b00, 8'h00, 1'b0, 8'h00, 1'b0};
        vecs[4] = '{16'h81AC, 8'h55, 1'b0, 1'b1, 1'b1, 8'h00, 0, 2'b00, 8'h00, 1'b0, 8'h00, 1'b0};
        vecs[5] = '{16'h83AB, 8'h55, 1'b1, 1'b1, 1'b0, 8'h00, 0, 2'b00, 8'h00, 1'b0, 8'h00, 1'b0};
        vecs[6] = '{16'h83AB, 8'h55, 1'b0, 1'b0, 1'b1, 8'h00, 0, 2'b00, 8'h00, 1'b0, 8'h00, 1'b1};

        // Reset state
        #2 rst_n = 1'b0;
        #1;
        chk("rst zd_out", {8'h00, zd_out}, 16'h0000);
        chk("rst zd_ena", {15'h0, zd_ena}, 16'h0000);
        chk("rst port_addr", {14'h0, port_addr}, 16'h0000);
        chk("rst port_wrdata", {8'h00, port_wrdata}, 16'h0000);
        chk("rst port_wrena", {15'h0, port_wrena}, 16'h0000);
        chk("rst port_wrstb_n", {15'h0, port_wrstb_n}, 16'h0001);
        chk("rst iorqge", {15'h0, iorqge}, 16'h0000);
        step(2);
        rst_n = 1'b1;
        step(6);

        // Table of single ZX cycles
        for (int v = 0; v < 7; v++) begin
            f0 = stb_falls;
            ena_seen = 1'b0;
            ge_seen = 1'b0;
            za = vecs[v].za;
            zd_in = vecs[v].zd;
            port_rddata = vecs[v].rddata;
            zm1_n = vecs[v].m1_n;
            zwr_n = vecs[v].wr_n;
            zrd_n = vecs[v].rd_n;
            ziorq_n = 1'b0;
            for (int c = 0; c < 10; c++) begin
                step(1);
                ena_seen |= zd_ena;
                ge_seen |= iorqge;
            end
            $display("vec %0d: za=%h wr_n=%b rd_n=%b m1_n=%b strobes=%0d zd_ena=%b zd_out=%h iorqge=%b",
                     v, vecs[v].za, vecs[v].wr_n, vecs[v].rd_n, vecs[v].m1_n,
                     stb_falls - f0, ena_seen, zd_out, ge_seen);
            chk($sformatf("vec%0d strobes", v), 16'(stb_falls - f0), 16'(vecs[v].exp_stb));
            chk($sformatf("vec%0d zd_ena", v), {15'h0, ena_seen}, {15'h0, vecs[v].exp_ena});
            chk($sformatf("vec%0d iorqge", v), {15'h0, ge_seen}, {15'h0, vecs[v].exp_ge});
            if (vecs[v].exp_stb > 0) begin
                chk($sformatf("vec%0d addr", v), {14'h0, cap_addr}, {14'h0, vecs[v].exp_addr});
                chk($sformatf("vec%0d data", v), {8'h00, cap_data}, {8'h00, vecs[v].exp_data});
            end
            if (vecs[v].exp_ena) begin
                chk($sformatf("vec%0d zd_out", v), {8'h00, zd_out}, {8'h00, vecs[v].exp_zd});
            end
            release_bus();
            chk($sformatf("vec%0d idle zd_ena", v), {15'h0, zd_ena}, 16'h0000);
        end

        // Write timing, #83AB <= 7C
        f0 = stb_falls;
        za = 16'h83AB; zd_in = 8'h7C; ziorq_n = 1'b0; zwr_n = 1'b0;
        step(2);
        chk("wr edge2 strobe", {15'h0, port_wrstb_n}, 16'h0001);
        step(1);
        chk("wr edge3 strobe", {15'h0, port_wrstb_n}, 16'h0000);
        chk("wr edge3 wrena", {15'h0, port_wrena}, 16'h0001);
        chk("wr edge3 addr", {14'h0, port_addr}, 16'h0003);
        chk("wr edge3 data", {8'h00, port_wrdata}, 16'h007C);
        step(1);
        chk("wr edge4 strobe", {15'h0, port_wrstb_n}, 16'h0000);
        step(1);
        chk("wr edge5 strobe", {15'h0, port_wrstb_n}, 16'h0001);
        chk("wr edge5 wrena", {15'h0, port_wrena}, 16'h0001);
        chk("wr edge5 data", {8'h00, port_wrdata}, 16'h007C);
        step(1);
        chk("wr edge6 wrena", {15'h0, port_wrena}, 16'h0000);
        step(4);
        chk("wr single strobe", 16'(stb_falls - f0), 16'd1);
        $display("write timing: #83AB strobes=%0d", stb_falls - f0);
        release_bus();

        // Read timing, #82AB, live data update and rd release
        za = 16'h82AB; port_rddata = 8'h35; ziorq_n = 1'b0; zrd_n = 1'b0;
        step(2);
        chk("rd edge2 zd_ena", {15'h0, zd_ena}, 16'h0000);
        step(1);
        chk("rd edge3 zd_ena", {15'h0, zd_ena}, 16'h0001);
        step(1);
        chk("rd edge4 zd_out", {8'h00, zd_out}, 16'h0035);
        port_rddata = 8'hCA;
        step(1);
        chk("rd follow zd_out", {8'h00, zd_out}, 16'h00CA);
        zrd_n = 1'b1;
        step(2);
        chk("rd synced-high zd_ena", {15'h0, zd_ena}, 16'h0001);
        step(1);
        chk("rd release zd_ena", {15'h0, zd_ena}, 16'h0000);
        $display("read timing: #82AB zd_out=%h", zd_out);
        release_bus();

        // Reset in the middle of a strobe
        za = 16'h83AB; zd_in = 8'h7C; ziorq_n = 1'b0; zwr_n = 1'b0;
        step(4);
        chk("mid-rst strobe low", {15'h0, port_wrstb_n}, 16'h0000);
        #2 rst_n = 1'b0;
        #1;
        chk("mid-rst strobe", {15'h0, port_wrstb_n}, 16'h0001);
        chk("mid-rst wrena", {15'h0, port_wrena}, 16'h0000);
        chk("mid-rst addr", {14'h0, port_addr}, 16'h0000);
        chk("mid-rst data", {8'h00, port_wrdata}, 16'h0000);
        step(2);
        rst_n = 1'b1;
        f0 = stb_falls;
        step(10);
        chk("post-rst no strobe", 16'(stb_falls - f0), 16'd0);
        chk("post-rst strobe high", {15'h0, port_wrstb_n}, 16'h0001);
        ziorq_n = 1'b1; zwr_n = 1'b1;
        step(3);
        zd_in = 8'h5A; ziorq_n = 1'b0; zwr_n = 1'b0;
        step(10);
        chk("fresh write strobe", 16'(stb_falls - f0), 16'd1);
        chk("fresh write data", {8'h00, cap_data}, 16'h005A);
        $display("reset mid-write: fresh strobes=%0d data=%h", stb_falls - f0, cap_data);
        release_bus();

        // Back-to-back writes with 2 idle fclk between
        cap_q.delete();
        f0 = stb_falls;
        za = 16'h81AB; zd_in = 8'h01; ziorq_n = 1'b0; zwr_n = 1'b0;
        step(8);
        ziorq_n = 1'b1; zwr_n = 1'b1;
        step(2);
        za = 16'h82AB; zd_in = 8'h14; ziorq_n = 1'b0; zwr_n = 1'b0;
        step(8);
        release_bus();
        chk("b2b strobes", 16'(stb_falls - f0), 16'd2);
        chk("b2b captures", 16'(cap_q.size()), 16'd2);
        if (cap_q.size() == 2) begin
            chk("b2b first", {6'h0, cap_q[0]}, {6'h0, 2'b01, 8'h01});
            chk("b2b second", {6'h0, cap_q[1]}, {6'h0, 2'b10, 8'h14});
        end
        $display("back-to-back: strobes=%0d", stb_falls - f0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
